fifo_rr_drain: RTL and testbench

//  Downstream of NUM_SRC first-word-fall-through FIFOs (per-warp / per-lane queues). Each cycle it

---
 rtl/fifo_rr_drain_pkg.sv | 9 +
 rtl/fifo_rr_drain_rr_arbiter.sv | 51 +++++
 rtl/fifo_rr_drain.sv | 87 ++++++++
 tb/tb_fifo_rr_drain.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rr_drain_pkg.sv
// Shared helpers for the round-robin FIFO drain block and its arbiter.
package fifo_rr_drain_pkg;

  // Index width for n sources; a single source still needs one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_rr_drain_rr_arbiter.sv
// Combinational round-robin arbiter: lowest set request at or after ptr_i,
// wrapping, found by a priority scan over the request vector doubled.
module rr_arbiter
  import fifo_rr_drain_pkg::*;
#(
  parameter int N = 4,
  localparam int SRC_W = idx_width(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [SRC_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_onehot_o,
  output logic [SRC_W-1:0] gnt_idx_o,
  output logic             any_o
);

  logic [2*N-1:0] req_dbl;
  logic [2*N-1:0] mask;
  logic [2*N-1:0] masked;
  logic           found;

  assign req_dbl = {req_i, req_i};
  assign any_o   = |req_i;

  // The upper copy is never masked, so any request is reached within N positions of ptr_i.
  genvar gi;
  generate
    for (gi = 0; gi < 2 * N; gi++) begin : g_mask
      assign mask[gi] = ({1'b0, ptr_i} <= (SRC_W + 1)'(gi));
    end
  endgenerate

  assign masked = req_dbl & mask;

  always_comb begin
    gnt_idx_o = '0;
    found     = 1'b0;
    for (int j = 0; j < 2 * N; j++) begin
      if (!found && masked[j]) begin
        found     = 1'b1;
        gnt_idx_o = (j >= N) ? SRC_W'(j - N) : SRC_W'(j);
      end
    end
  end

  generate
    for (gi = 0; gi < N; gi++) begin : g_onehot
      assign gnt_onehot_o[gi] = any_o && (gnt_idx_o == SRC_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/fifo_rr_drain.sv
// Round-robin drain of NUM_SRC FWFT FIFOs into one registered valid/ready output stage.
module fifo_rr_drain
  import fifo_rr_drain_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 32,
  localparam int SRC_W     = idx_width(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_SRC-1:0]            src_empty_i,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data_i,
  output logic [NUM_SRC-1:0]            src_r_en_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [DATA_WIDTH-1:0]         out_data_o,
  output logic [SRC_W-1:0]              out_src_o
);

  logic [NUM_SRC-1:0]    req;
  logic [NUM_SRC-1:0]    gnt_onehot;
  logic [SRC_W-1:0]      gnt_idx;
  logic                  any_req;
  logic                  load_en;
  logic                  pop;
  logic [DATA_WIDTH-1:0] src_word [NUM_SRC];

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [SRC_W-1:0]      out_src_q, out_src_d;
  logic [SRC_W-1:0]      rr_ptr_q, rr_ptr_d;

  assign req = ~src_empty_i;

  rr_arbiter #(.N(NUM_SRC)) u_arb (
    .req_i        (req),
    .ptr_i        (rr_ptr_q),
    .gnt_onehot_o (gnt_onehot),
    .gnt_idx_o    (gnt_idx),
    .any_o        (any_req)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_word
      assign src_word[gi] = src_data_i[DATA_WIDTH*(gi+1)-1 -: DATA_WIDTH];
    end
  endgenerate

  always_comb begin
    load_en     = !out_valid_q || out_ready_i;
    pop         = load_en && any_req;
    // Gated by rst_n so the FIFOs are never popped while the output stage is held in reset.
    src_r_en_o  = (pop && rst_n) ? gnt_onehot : '0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    rr_ptr_d    = rr_ptr_q;
    if (pop) begin
      out_valid_d = 1'b1;
      out_data_d  = src_word[gnt_idx];
      out_src_d   = gnt_idx;
      rr_ptr_d    = (gnt_idx == SRC_W'(NUM_SRC - 1)) ? '0 : gnt_idx + SRC_W'(1);
    end else if (load_en) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_src_o   = out_src_q;

endmodule

// File: tb/tb_fifo_rr_drain.sv
// Randomized bench for fifo_rr_drain against a queue-level model of round-robin draining.
module tb_fifo_rr_drain;

  localparam int NS = 4;
  localparam int DW = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NS-1:0]  src_empty;
  logic [NS*DW-1:0] src_data;
  logic [NS-1:0]  src_r_en;
  logic           out_valid;
  logic           out_ready;
  logic [DW-1:0]  out_data;
  logic [1:0]     out_src;

  logic [2:0]     empty3;
  logic [3*DW-1:0] data3;
  logic [2:0]     ren3;
  logic           valid3;
  logic           ready3;
  logic [DW-1:0]  odata3;
  logic [1:0]     osrc3;

  always #5 clk = ~clk;

  fifo_rr_drain #(.NUM_SRC(NS), .DATA_WIDTH(DW)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .src_empty_i (src_empty),
    .src_data_i  (src_data),
    .src_r_en_o  (src_r_en),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_src_o   (out_src)
  );

  fifo_rr_drain #(.NUM_SRC(3), .DATA_WIDTH(DW)) u_dut3 (
    .clk         (clk),
    .rst_n       (rst_n),
    .src_empty_i (empty3),
    .src_data_i  (data3),
    .src_r_en_o  (ren3),
    .out_valid_o (valid3),
    .out_ready_i (ready3),
    .out_data_o  (odata3),
    .out_src_o   (osrc3)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // FIFO contents log: head = next to pop, chead = next expected at the consumer, tail = next write.
  logic [31:0] fmem [NS][64];
  int          head  [NS];
  int          chead [NS];
  int          tail  [NS];
  int          word_ctr = 0;

  bit          m_valid;
  logic [31:0] m_data;
  int          m_src;
  int          m_ptr;
  logic [NS-1:0] last_ren;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive();
    for (int i = 0; i < NS; i++) begin
      src_empty[i] = (head[i] == tail[i]);
      src_data[i*DW +: DW] = src_empty[i] ? (32'hDEAD_0000 + 32'(i)) : fmem[i][head[i] % 64];
    end
  endtask

  task automatic push(input int i, input logic [31:0] w);
    if (tail[i] - chead[i] < 63) begin
      fmem[i][tail[i] % 64] = w;
      tail[i]++;
    end
  endtask

  task automatic push_uniq(input int i);
    push(i, {8'(i), 24'(word_ctr)});
    word_ctr++;
  endtask

  function automatic bit pending();
    bit p = 1'b0;
    for (int i = 0; i < NS; i++) if (head[i] != tail[i]) p = 1'b1;
    return p;
  endfunction

  // One clock: check at negedge, advance the model at posedge, drive new inputs just after.
  task automatic step(input bit rdy);
    int g;
    bit ld;
    @(negedge clk);
    ld = !m_valid || out_ready;
    g  = -1;
    if (ld) begin
      for (int k = 0; k < NS; k++) begin
        int i;
        i = (m_ptr + k) % NS;
        if (g < 0 && head[i] != tail[i]) g = i;
      end
    end
    last_ren = src_r_en;
    check("r_en", 64'(src_r_en), (g < 0) ? 64'd0 : (64'd1 << g));
    check("onehot0", 64'($onehot0(src_r_en)), 64'd1);
    check("valid", 64'(out_valid), 64'(m_valid));
    if (m_valid) begin
      check("data", 64'(out_data), 64'(m_data));
      check("src", 64'(out_src), 64'(m_src));
    end
    if (m_valid && out_ready) begin
      check("order", 64'(out_data), 64'(fmem[m_src][chead[m_src] % 64]));
      chead[m_src]++;
      $display("xfer src=%0d data=%h", out_src, out_data);
    end
    @(posedge clk);
    if (g >= 0) begin
      m_valid = 1'b1;
      m_data  = fmem[g][head[g] % 64];
      m_src   = g;
      m_ptr   = (g + 1) % NS;
      head[g]++;
    end else if (ld) begin
      m_valid = 1'b0;
    end
    #1;
    out_ready = rdy;
    drive();
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int n = 0; n < 200 && (pending() || m_valid); n++) step(1'b1);
    check("drain_done", 64'(pending() || m_valid), 64'd0);
  endtask

  logic [31:0] held_data;
  logic [1:0]  held_src;

  initial begin
    for (int i = 0; i < NS; i++) begin
      head[i] = 0; chead[i] = 0; tail[i] = 0;
    end
    m_valid = 1'b0; m_data = '0; m_src = 0; m_ptr = 0; last_ren = '0;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    empty3    = 3'b111;
    data3     = {32'hB2, 32'hB1, 32'hB0};
    ready3    = 1'b1;
    drive();

    // Reset with every FIFO empty
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_ren", 64'(src_r_en), 64'd0);
      check("rst_src", 64'(out_src), 64'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) step(1'b1);

    // All four FIFOs non-empty: strict rotation, one pop per cycle
    for (int i = 0; i < NS; i++) push(i, 32'hA0 + 32'(i));
    for (int r = 0; r < 5; r++) for (int i = 0; i < NS; i++) push_uniq(i);
    drive();
    for (int k = 0; k < 5; k++) begin
      step(1'b1);
      check("rot_src", 64'(out_src), 64'(k % NS));
      check("rot_pulse", 64'(last_ren), 64'd1 << (k % NS));
      if (k < NS) check("rot_data", 64'(out_data), 64'h0A0 + 64'(k));
    end
    drain();

    // Only FIFO 2 holds words, pointer parked at 3
    push_uniq(2); drive();
    step(1'b1);
    step(1'b1);
    for (int k = 0; k < 3; k++) push_uniq(2);
    drive();
    for (int k = 0; k < 3; k++) begin
      step(1'b1);
      check("wrap_src", 64'(out_src), 64'd2);
      check("wrap_ren", 64'(last_ren), 64'b0100);
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b1);
      check("wrap_idle_ren", 64'(last_ren), 64'd0);
    end

    // Consumer stall with a word held
    for (int k = 0; k < 3; k++) begin
      push_uniq(0); push_uniq(1);
    end
    drive();
    step(1'b0);
    held_data = out_data;
    held_src  = out_src;
    for (int k = 0; k < 5; k++) begin
      step(k == 4);
      check("stall_data", 64'(out_data), 64'(held_data));
      check("stall_src", 64'(out_src), 64'(held_src));
      check("stall_ren", 64'(last_ren), 64'd0);
    end
    step(1'b0);
    check("release_pop", 64'(|last_ren), 64'd1);

    // Reset asserted while a word is held
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_ren", 64'(src_r_en), 64'd0);
    if (m_valid) chead[m_src]++;
    m_valid = 1'b0;
    m_ptr   = 0;
    @(posedge clk);
    #1;
    check("midrst_hold_valid", 64'(out_valid), 64'd0);
    check("midrst_hold_ren", 64'(src_r_en), 64'd0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    drive();
    drain();

    // Random empty/ready traffic against the model and per-source order scoreboard
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(99) < 70);
      for (int i = 0; i < NS; i++) if ($urandom_range(99) < 30) push_uniq(i);
      drive();
    end
    drain();

    // Three-source instance: wraps 2 -> 0
    empty3 = 3'b000;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("ns3_ren", 64'(ren3), 64'd1 << (k % 3));
      @(posedge clk);
      #1;
      check("ns3_src", 64'(osrc3), 64'(k % 3));
      check("ns3_valid", 64'(valid3), 64'd1);
      check("ns3_data", 64'(odata3), 64'h0B0 + 64'(k % 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
